// File: rtl/strand_assembler.sv
// Serial quaternary-digit strand assembler: packs digits left-justified into a 2*N-bit word
// and classifies the strand as full, single-deletion or bad. Optional stats: STRAND_ASSEMBLER_STATS_EN.
module strand_assembler #(
  parameter int N  = 98,
  parameter int CW = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dig_valid,
  output logic            dig_ready,
  input  logic [1:0]      dig_data,
  input  logic            dig_last,
  input  logic            strand_rev,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*N-1:0]  word_out,
  output logic            out_del,
  output logic            out_rev,
  output logic            out_err,
  output logic [CW-1:0]   digit_cnt
`ifdef STRAND_ASSEMBLER_STATS_EN
  ,
  input  logic            clr_stats,
  output logic [15:0]     cnt_full,
  output logic [15:0]     cnt_del,
  output logic [15:0]     cnt_err
`endif
);

  typedef enum logic [1:0] {IDLE, COLLECT, OUT, DRAIN} state_t;

  localparam logic [CW-1:0] N_C  = CW'(N);
  localparam logic [CW-1:0] N1_C = CW'(N - 1);

  state_t          state, state_nxt;
  logic [2*N-1:0]  word_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic [CW-1:0]   cnt_inc;
  logic            del_nxt, rev_nxt, err_nxt;
  logic            accept, handshake;

  assign cnt_inc = digit_cnt + CW'(1);

  always_comb begin
    state_nxt = state;
    word_nxt  = word_out;
    cnt_nxt   = digit_cnt;
    del_nxt   = out_del;
    rev_nxt   = out_rev;
    err_nxt   = out_err;
    dig_ready = (state != OUT);
    out_valid = (state == OUT);
    accept    = dig_valid && dig_ready;
    handshake = out_valid && out_ready;

    case (state)
      IDLE: begin
        if (accept) begin
          word_nxt            = '0;
          word_nxt[2*N-1 -: 2] = dig_data;
          cnt_nxt             = CW'(1);
          rev_nxt             = strand_rev;
          del_nxt             = 1'b0;
          err_nxt             = dig_last;
          state_nxt           = dig_last ? OUT : COLLECT;
        end
      end
      COLLECT: begin
        if (accept) begin
          // Digit slot selected by the running count; constant slices keep the mux explicit.
          for (int unsigned k = 0; k < N; k++) begin
            if (digit_cnt == CW'(k)) word_nxt[2*N-1-2*k -: 2] = dig_data;
          end
          cnt_nxt = cnt_inc;
          if (dig_last) begin
            del_nxt   = (cnt_inc == N1_C);
            err_nxt   = (cnt_inc != N_C) && (cnt_inc != N1_C);
            state_nxt = OUT;
          end else if (cnt_inc == N_C) begin
            err_nxt   = 1'b1;
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (accept) begin
          cnt_nxt = N_C;
          if (dig_last) begin
            err_nxt   = 1'b1;
            del_nxt   = 1'b0;
            state_nxt = OUT;
          end
        end
      end
      OUT: begin
        if (handshake) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      word_out  <= '0;
      digit_cnt <= '0;
      out_del   <= 1'b0;
      out_rev   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      word_out  <= word_nxt;
      digit_cnt <= cnt_nxt;
      out_del   <= del_nxt;
      out_rev   <= rev_nxt;
      out_err   <= err_nxt;
    end
  end

`ifdef STRAND_ASSEMBLER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      cnt_full <= '0;
      cnt_del  <= '0;
      cnt_err  <= '0;
    end else if (handshake) begin
      if (out_err) begin
        if (cnt_err != '1) cnt_err <= cnt_err + 16'd1;
      end else if (out_del) begin
        if (cnt_del != '1) cnt_del <= cnt_del + 16'd1;
      end else begin
        if (cnt_full != '1) cnt_full <= cnt_full + 16'd1;
      end
    end
  end
`endif

endmodule
